// File: rtl/sum_display.sv
`default_nettype none
// ============================================================================
//  Module   : sum_display
//  Purpose  : Captures a 5-bit adder result and drives it as a two-digit
//             multiplexed active-low 7-segment display with tens blanking.
//  Revision : 1.0
// ============================================================================
module sum_display #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       co,
    input  logic [3:0] zi,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       valid,
    output logic       ovf
);

    localparam int                 c_cnt_w   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [6:0]         c_blank   = 7'h7F;

    logic [4:0]         val_q,   val_d;
    logic               valid_q, valid_d;
    logic               ovf_q,   ovf_d;
    logic [c_cnt_w-1:0] cnt_q,   cnt_d;
    logic               sel_q,   sel_d;
    logic [6:0]         seg_q,   seg_d;
    logic [1:0]         an_q,    an_d;
    logic               cnt_wrap;
    logic [1:0]         tens;
    logic [3:0]         units;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = c_blank;
        endcase
    endfunction

    always_comb begin
        val_d   = val_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (load) begin
            val_d   = {co, zi};
            valid_d = 1'b1;
            ovf_d   = co;
        end

        cnt_wrap = (cnt_q == c_cnt_max);
        cnt_d    = cnt_wrap ? '0 : cnt_q + c_cnt_one;
        sel_d    = sel_q ^ cnt_wrap;

        // Value never exceeds 31, so a compare chain replaces a divider.
        if (val_q >= 5'd30) begin
            tens  = 2'd3;
            units = 4'(val_q - 5'd30);
        end else if (val_q >= 5'd20) begin
            tens  = 2'd2;
            units = 4'(val_q - 5'd20);
        end else if (val_q >= 5'd10) begin
            tens  = 2'd1;
            units = 4'(val_q - 5'd10);
        end else begin
            tens  = 2'd0;
            units = val_q[3:0];
        end

        an_d  = 2'b11;
        seg_d = c_blank;
        if (valid_q) begin
            if (!sel_q) begin
                an_d  = 2'b10;
                seg_d = seg_code(units);
            end else if (tens != 2'd0) begin
                an_d  = 2'b01;
                seg_d = seg_code({2'b00, tens});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            seg_q   <= c_blank;
            an_q    <= 2'b11;
        end else begin
            val_q   <= val_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: doc/sum_display.md
SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 Parameter: REFRESH_DIV, 4, clock cycles per displayed digit slot (legal range 2..2^20).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  capture strobe; samples co/zi when high at a rising clk edge.
REQ-005 co  input  1  carry-out of the upstream 4-bit adder.
REQ-006 zi  input  4  sum bits of the upstream 4-bit adder.
REQ-007 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 an  output  2  digit anodes, active-low; an[0] units, an[1] tens, registered.
REQ-009 valid  output  1  high once a result has been captured since reset.
REQ-010 ovf  output  1  registered copy of captured co.

Function
REQ-011 load=1 at edge N: result register val[4:0] <= {co,zi}; ovf <= co; valid <= 1; all at edge N.
REQ-012 load=0: val, ovf, valid hold.
REQ-013 Value range 0..31; tens = val/10 (0..3), units = val%10 (0..9), combinational from val.
REQ-014 Refresh counter cnt counts 0..REFRESH_DIV-1, increments every cycle, wraps to 0.
REQ-015 Digit select sel toggles at the edge where cnt wraps from REFRESH_DIV-1 to 0; sel=0 units, sel=1 tens.
REQ-016 seg/an updated every edge from val, sel and valid in effect before that edge; new captured value visible on outputs at edge N+1 (one cycle latency after capture).
REQ-017 Segment codes (hex, seg[6:0]): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10; blank=7F.
REQ-018 sel=0 and valid=1: an=2'b10, seg=code(units).
REQ-019 sel=1, valid=1, tens!=0: an=2'b01, seg=code(tens).
REQ-020 sel=1, tens=0: leading-zero blanking; an=2'b11, seg=7F.
REQ-021 valid=0: an=2'b11, seg=7F regardless of sel.
REQ-022 Counter and sel run continuously; load never resets cnt or sel.
REQ-023 load held high for multiple cycles: recapture every cycle; last sampled value wins.
REQ-024 Never more than one anode low in any cycle.

Reset
REQ-025 rst=1 forces immediately, without clock: val=0, valid=0, ovf=0, cnt=0, sel=0, an=2'b11, seg=7F.
REQ-026 rst asserted mid-display or coincident with load: reset wins; load ignored while rst=1.
REQ-027 After rst deasserts, first counter increment at the first rising edge; display stays blank until first load.

Verification
REQ-028 Reset then no load for 3*REFRESH_DIV cycles -> an=2'b11, seg=7F, valid=0, ovf=0 throughout.
REQ-029 load with co=0, zi=4'h7 -> after next edge sel=0 slots show an=2'b10 seg=78; sel=1 slots an=2'b11 seg=7F; ovf=0.
REQ-030 load with co=1, zi=4'hE (30) -> units slot an=2'b10 seg=40; tens slot an=2'b01 seg=30; ovf=1.
REQ-031 load co=1, zi=4'hF (31) then co=0, zi=4'h9 (9) on consecutive cycles -> displays 9, tens blanked, ovf=0.
REQ-032 Assert rst asynchronously (between edges) while displaying 30 -> an=2'b11, seg=7F, valid=0 within same cycle; sel=0, cnt=0 on release.
REQ-033 REFRESH_DIV=4, free run -> sel toggles exactly every 4 cycles; an never 2'b00.
